irrigation_controller: RTL
==========================

IRRIGATION_CONTROLLER -- requirements
Module: irrigation_controller

Interface
REQ-001 Parameter RUN_CYCLES, default 16: clock cycles per irrigation grant (legal range 1..2^CNT_W-1).
REQ-002 Parameter FILL_TIMEOUT, default 64: maximum FILL cycles before fault (legal range 1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 16: width of the shared run/fill counter.
REQ-004 The block SHALL have one clock, clk; reset rstn is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 l, m, h  input  1 each  tank level probes for low, mid and high; 1 = water present at that probe.
REQ-008 req_as  input  1  sprinkler irrigation request, level-sensitive.
REQ-009 req_gt  input  1  drip irrigation request, level-sensitive.
REQ-010 fault_clr  input  1  operator fault acknowledge, level-sensitive.
REQ-011 valve_in  output  1  tank inlet valve, active in FILL only.
REQ-012 valve_as  output  1  sprinkler valve, active in IRR_AS only.
REQ-013 valve_gt  output  1  drip valve, active in IRR_GT only.
REQ-014 alarm  output  1  active in FAULT only.
REQ-015 done  output  1  one-cycle pulse on natural completion of an irrigation grant.
REQ-016 state  output  3  IDLE=0, FILL=1, IRR_AS=2, IRR_GT=3, FAULT=4.

Function
REQ-017 The block SHALL register l, m, h, req_as, req_gt and fault_clr once; all decisions SHALL use the registered copies only.
REQ-018 Level decode from {h,m,l} SHALL be: 000 EMPTY, 001 LOW, 011 MID, 111 FULL; every other code SHALL be SENSOR_FAULT.
REQ-019 valve_in, valve_as, valve_gt, alarm and state SHALL be Moore outputs decoded from the state register; a change on any input SHALL reach the outputs 2 clk edges later.
REQ-020 Eligibility SHALL be: as_ok = req_as and level in {MID, FULL}; gt_ok = req_gt and level in {LOW, MID, FULL}.
REQ-021 IDLE SHALL evaluate the following in priority order:
- SENSOR_FAULT -> FAULT;
- EMPTY -> FILL;
- exactly one of as_ok/gt_ok -> the matching IRR state;
- both eligible -> the IRR state not recorded in last_served;
- otherwise -> remain in IDLE.
REQ-022 On every grant the block SHALL update last_served to the granted channel and load the counter with RUN_CYCLES-1; last_served SHALL reset to GT, so the first contended grant goes to AS.
REQ-023 IRR_AS and IRR_GT SHALL evaluate the following each cycle, in priority order:
- SENSOR_FAULT -> FAULT;
- EMPTY -> FILL;
- channel request low or level below the channel threshold -> IDLE (abort, no done pulse);
- counter == 0 -> IDLE with done=1 for one cycle;
- otherwise -> decrement the counter.
REQ-024 A valve SHALL be open for exactly RUN_CYCLES cycles on an uninterrupted grant.
REQ-025 FILL SHALL load the counter with 0 on entry and increment it each cycle, then evaluate in priority order:
- SENSOR_FAULT -> FAULT;
- FULL -> IDLE;
- counter == FILL_TIMEOUT-1 -> FAULT;
- otherwise -> remain in FILL.
REQ-026 FAULT SHALL hold every valve at 0 and alarm at 1; FAULT SHALL exit to IDLE only when fault_clr=1 and the decoded level is not SENSOR_FAULT.
REQ-027 The counter SHALL never wrap; the IRR and FILL exit conditions SHALL take effect before 0 or 2^CNT_W-1 is crossed.
REQ-028 At most one of valve_in, valve_as and valve_gt SHALL be 1 in any cycle.
REQ-029 Unused state encodings 5..7 SHALL transition to FAULT on the next edge.

Reset
REQ-030 With rstn=0 at a rising edge, the block SHALL set state to IDLE, all outputs to 0, the counter to 0, last_served to GT, and all input registers to 0; reset asserted mid-grant or mid-fill SHALL abort it with no done pulse.
REQ-031 The block SHALL make no state transition during the first edge after rstn deasserts, because the input registers still hold their reset zeros.

Verification (RUN_CYCLES=4, FILL_TIMEOUT=8)
REQ-032 The bench SHALL apply level MID, req_as=1 held: valve_as=1 for exactly 4 cycles, then done=1 for 1 cycle, then state=IDLE for 1 cycle, then a re-grant to AS.
REQ-033 The bench SHALL apply level FULL, req_as=req_gt=1 held: the controller SHALL alternate grants AS, GT, AS, GT, with each valve open for 4 cycles.
REQ-034 The bench SHALL apply req_gt=1 at level LOW, then drop the level to EMPTY mid-grant: valve_gt SHALL fall and valve_in SHALL rise 2 edges later, with no done pulse; raising the level to FULL SHALL return the state to IDLE.
REQ-035 The bench SHALL apply level EMPTY held for 10 cycles: valve_in=1 for 8 cycles, then state=FAULT with alarm=1; fault_clr=1 with the level still EMPTY SHALL give IDLE, then FILL again.
REQ-036 The bench SHALL apply {h,m,l}=101 during IRR_AS: state SHALL become FAULT with all valves 0; fault_clr=1 while the code is still 101 SHALL keep FAULT; fault_clr=1 with the code at 011 SHALL give IDLE.
REQ-037 The bench SHALL pulse rstn=0 for 1 cycle during FILL: all outputs SHALL be 0 at the next edge and state SHALL be IDLE with no done pulse.

Source files
------------

// File: rtl/irrigation_controller.sv
// Irrigation controller: tank fill management plus alternating sprinkler/drip
// grants, with a latched fault state for sensor errors and fill timeouts.
module irrigation_controller #(
  parameter int unsigned RUN_CYCLES   = 16,
  parameter int unsigned FILL_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       l,
  input  logic       m,
  input  logic       h,
  input  logic       req_as,
  input  logic       req_gt,
  input  logic       fault_clr,
  output logic       valve_in,
  output logic       valve_as,
  output logic       valve_gt,
  output logic       alarm,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_IRR_AS = 3'd2;
  localparam logic [2:0] ST_IRR_GT = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

  // Registered input copies; in_vld_q marks that they hold real samples
  logic l_q, m_q, h_q, req_as_q, req_gt_q, fault_clr_q, in_vld_q;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_gt_q, last_gt_d;  // 1: last grant went to drip
  logic             done_q, done_d;

  // Decoded tank level
  logic [2:0] lvl_code;
  logic       lv_empty, lv_low, lv_mid, lv_full, lv_fault;
  logic       as_ok, gt_ok, as_lvl_ok, gt_lvl_ok;

  // Level decode and channel eligibility from the registered inputs
  always_comb begin
    lvl_code  = {h_q, m_q, l_q};
    lv_empty  = (lvl_code == 3'b000);
    lv_low    = (lvl_code == 3'b001);
    lv_mid    = (lvl_code == 3'b011);
    lv_full   = (lvl_code == 3'b111);
    lv_fault  = !(lv_empty || lv_low || lv_mid || lv_full);
    as_lvl_ok = lv_mid || lv_full;
    gt_lvl_ok = lv_low || lv_mid || lv_full;
    as_ok     = req_as_q && as_lvl_ok;
    gt_ok     = req_gt_q && gt_lvl_ok;
  end

  // State, counter, arbitration history and input sampling registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      l_q         <= 1'b0;
      m_q         <= 1'b0;
      h_q         <= 1'b0;
      req_as_q    <= 1'b0;
      req_gt_q    <= 1'b0;
      fault_clr_q <= 1'b0;
      in_vld_q    <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_gt_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      l_q         <= l;
      m_q         <= m;
      h_q         <= h;
      req_as_q    <= req_as;
      req_gt_q    <= req_gt;
      fault_clr_q <= fault_clr;
      in_vld_q    <= 1'b1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gt_q   <= last_gt_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counter and grant logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_gt_d = last_gt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Input copies still hold reset zeros on the first edge out of reset
        if (!in_vld_q) begin
          state_d = ST_IDLE;
        end else if (lv_fault) begin
          state_d = ST_FAULT;
        end else if (lv_empty) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end else if (as_ok && (!gt_ok || last_gt_q)) begin
          state_d   = ST_IRR_AS;
          cnt_d     = RUN_LOAD;
          last_gt_d = 1'b0;
        end else if (gt_ok) begin
          state_d   = ST_IRR_GT;
          cnt_d     = RUN_LOAD;
          last_gt_d = 1'b1;
        end
      end
      ST_FILL: begin
        if (lv_fault) begin
          state_d = ST_FAULT;
        end else if (lv_full) begin
          state_d = ST_IDLE;
        end else if (cnt_q == FILL_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IRR_AS: begin
        if (lv_fault) begin
          state_d = ST_FAULT;
        end else if (lv_empty) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end else if (!req_as_q || !as_lvl_ok) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_IRR_GT: begin
        if (lv_fault) begin
          state_d = ST_FAULT;
        end else if (lv_empty) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end else if (!req_gt_q || !gt_lvl_ok) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (fault_clr_q && !lv_fault) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    valve_in = 1'b0;
    valve_as = 1'b0;
    valve_gt = 1'b0;
    alarm    = 1'b0;
    case (state_q)
      ST_FILL:   valve_in = 1'b1;
      ST_IRR_AS: valve_as = 1'b1;
      ST_IRR_GT: valve_gt = 1'b1;
      ST_FAULT:  alarm    = 1'b1;
      default:   ;
    endcase
    state = state_q;
    done  = done_q;
  end

endmodule
